// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: state encoding, output bundle and step-width helper.
// The opcode decoder and top-level benches reuse the encoding and the width function.
package cpu_ctrl_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] ST_IDLE  = 5'd0;
    localparam logic [STATE_W-1:0] ST_HALT  = 5'd1;
    localparam logic [STATE_W-1:0] ST_FAULT = 5'd2;
    localparam logic [STATE_W-1:0] ST_T0    = 5'd3;

    // Control steps are contiguous from ST_T0, so Ti encodes as ST_T0 + i.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_HALT  = ST_HALT,
        S_FAULT = ST_FAULT,
        S_T0    = ST_T0,
        S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8,
        S_T9, S_T10, S_T11, S_T12, S_T13, S_T14, S_T15
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic zlow_in;
        logic zlow_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
    } ctrl_t;

    function automatic int step_w(input int max_step);
        return (max_step < 1) ? 1 : $clog2(max_step + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts T1 cycles spent waiting on memory; flags the cycle whose wait would reach MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP  = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!clear || restart) begin
            count <= '0;
        end else if (enable && (count != CAP)) begin
            count <= count + 1'b1;
        end
    end

    // Asserted on the edge that would record the MEM_TIMEOUT-th wait.
    assign expired = enable && (count == TERM);

endmodule

// File: rtl/fetch_sequencer.sv
// Control-step generator: runs the T0..T2 fetch micro-ops itself and hands T3+ to the decoder.
// Every output is a flop loaded from the decode of the next state, so outputs track the state register.
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_STEP    = 7,
    parameter int MEM_TIMEOUT = 15,
    parameter int STEP_W      = step_w(MAX_STEP)
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                halt_req,
    input  logic                mem_ready,
    input  logic                end_instr,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                ZLowIn,
    output logic                ZLowOut,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic [MAX_STEP:0]   step,
    output logic [STEP_W-1:0]   step_num,
    output logic                exec_valid,
    output logic                running,
    output logic                halted,
    output logic                mem_fault,
    output logic [STATE_W-1:0]  state
);

    localparam state_e S_LAST = state_e'(ST_T0 + STATE_W'(MAX_STEP));

    state_e state_q;
    state_e state_d;
    logic   wait_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clock   (clock),
        .clear   (clear),
        .restart (state_q != S_T1),
        .enable  ((state_q == S_T1) && !mem_ready),
        .expired (wait_expired)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run && !halt_req) state_d = S_T0;
            end
            S_T0:    state_d = S_T1;
            S_T1: begin
                if (mem_ready)         state_d = S_T2;
                else if (wait_expired) state_d = S_FAULT;
            end
            S_T2:    state_d = S_T3;
            S_FAULT: state_d = S_FAULT;
            default: begin
                // Execute steps; anything at or past the last step ends the instruction.
                if (end_instr || (state_q >= S_LAST)) begin
                    if (halt_req)  state_d = S_HALT;
                    else if (!run) state_d = S_IDLE;
                    else           state_d = S_T0;
                end else begin
                    state_d = state_e'(state_q + 1'b1);
                end
            end
        endcase
    end

    ctrl_t               ctrl_d, ctrl_q;
    logic [MAX_STEP:0]   step_d;
    logic [STEP_W-1:0]   step_num_d;
    logic [STATE_W-1:0]  step_idx;
    logic                running_d;
    logic                exec_d;

    always_comb begin
        ctrl_d     = '0;
        step_d     = '0;
        step_num_d = '0;
        step_idx   = '0;
        running_d  = (state_d >= S_T0) && (state_d <= S_LAST);
        exec_d     = (state_d >= S_T3) && (state_d <= S_LAST);

        case (state_d)
            S_T0: begin
                ctrl_d.pc_out  = 1'b1;
                ctrl_d.mar_in  = 1'b1;
                ctrl_d.inc_pc  = 1'b1;
                ctrl_d.zlow_in = 1'b1;
            end
            S_T1: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
                ctrl_d.pc_in    = (state_q != S_T1);
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            default: ;
        endcase

        if (running_d) begin
            step_idx = state_d - ST_T0;
            if (step_idx > STATE_W'(MAX_STEP)) step_idx = STATE_W'(MAX_STEP);
            step_num_d = STEP_W'(step_idx);
            for (int i = 0; i <= MAX_STEP; i++) begin
                step_d[i] = (step_idx == STATE_W'(i));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            ctrl_q     <= '0;
            step       <= '0;
            step_num   <= '0;
            exec_valid <= 1'b0;
            running    <= 1'b0;
            halted     <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            step       <= step_d;
            step_num   <= step_num_d;
            exec_valid <= exec_d;
            running    <= running_d;
            halted     <= (state_d == S_HALT);
            mem_fault  <= (state_d == S_FAULT);
        end
    end

    assign PCout   = ctrl_q.pc_out;
    assign MARin   = ctrl_q.mar_in;
    assign IncPC   = ctrl_q.inc_pc;
    assign ZLowIn  = ctrl_q.zlow_in;
    assign ZLowOut = ctrl_q.zlow_out;
    assign PCin    = ctrl_q.pc_in;
    assign Read    = ctrl_q.read;
    assign MDRin   = ctrl_q.mdr_in;
    assign MDRout  = ctrl_q.mdr_out;
    assign IRin    = ctrl_q.ir_in;
    assign state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (MAX_STEP=7, MEM_TIMEOUT=4) with hand-computed expectations.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       clear;
    logic       run;
    logic       halt_req;
    logic       mem_ready;
    logic       end_instr;
    logic       PCout, MARin, IncPC, ZLowIn, ZLowOut, PCin, Read, MDRin, MDRout, IRin;
    logic [7:0] step;
    logic [2:0] step_num;
    logic       exec_valid, running, halted, mem_fault;
    logic [4:0] dbg_state;

    int tests    = 0;
    int failures = 0;

    // Control vector order: PCout MARin IncPC ZLowIn ZLowOut PCin Read MDRin MDRout IRin
    localparam logic [9:0] C_NONE = 10'b0000_000000;
    localparam logic [9:0] C_T0   = 10'b1111_000000;
    localparam logic [9:0] C_T1F  = 10'b0000_111100;
    localparam logic [9:0] C_T1W  = 10'b0000_101100;
    localparam logic [9:0] C_T2   = 10'b0000_000011;

    // Status vector order: exec_valid running halted mem_fault
    localparam logic [3:0] S_FETCH = 4'b0100;
    localparam logic [3:0] S_EXEC  = 4'b1100;
    localparam logic [3:0] S_HALTD = 4'b0010;
    localparam logic [3:0] S_FLT   = 4'b0001;

    fetch_sequencer #(
        .MAX_STEP    (7),
        .MEM_TIMEOUT (4)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .end_instr  (end_instr),
        .PCout      (PCout),
        .MARin      (MARin),
        .IncPC      (IncPC),
        .ZLowIn     (ZLowIn),
        .ZLowOut    (ZLowOut),
        .PCin       (PCin),
        .Read       (Read),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .step       (step),
        .step_num   (step_num),
        .exec_valid (exec_valid),
        .running    (running),
        .halted     (halted),
        .mem_fault  (mem_fault),
        .state      (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_all(input string tag, input logic [9:0] ctrl, input logic [7:0] exp_step,
                              input logic [2:0] exp_num, input logic [3:0] status);
        check({tag, "/ctrl"}, 32'({PCout, MARin, IncPC, ZLowIn, ZLowOut, PCin, Read, MDRin, MDRout, IRin}), 32'(ctrl));
        check({tag, "/step"}, 32'(step), 32'(exp_step));
        check({tag, "/step_num"}, 32'(step_num), 32'(exp_num));
        check({tag, "/status"}, 32'({exec_valid, running, halted, mem_fault}), 32'(status));
    endtask

    task automatic exp_step(input string tag, input int i, input logic first_t1);
        logic [9:0] ctrl;
        logic [7:0] onehot;
        if (i == 0)      ctrl = C_T0;
        else if (i == 1) ctrl = first_t1 ? C_T1F : C_T1W;
        else if (i == 2) ctrl = C_T2;
        else             ctrl = C_NONE;
        onehot = 8'b1 << i;
        expect_all(tag, ctrl, onehot, 3'(i), (i >= 3) ? S_EXEC : S_FETCH);
    endtask

    task automatic exp_idle(input string tag);
        expect_all(tag, C_NONE, 8'h00, 3'd0, 4'b0000);
    endtask

    task automatic exp_halt(input string tag);
        expect_all(tag, C_NONE, 8'h00, 3'd0, S_HALTD);
    endtask

    task automatic exp_fault(input string tag);
        expect_all(tag, C_NONE, 8'h00, 3'd0, S_FLT);
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; end_instr = 1'b0;

        // Reset and idle
        tick(); tick();
        exp_idle("reset");
        clear = 1'b1;
        tick(); exp_idle("idle0");
        tick(); tick(); exp_idle("idle_hold");

        // Basic fetch, end_instr at T4, back-to-back fetch
        run = 1'b1; mem_ready = 1'b1;
        tick(); exp_step("basic_t0", 0, 1'b1);
        tick(); exp_step("basic_t1", 1, 1'b1);
        tick(); exp_step("basic_t2", 2, 1'b1);
        tick(); exp_step("basic_t3", 3, 1'b1);
        tick(); exp_step("basic_t4", 4, 1'b1);
        end_instr = 1'b1;
        tick(); exp_step("basic_back_t0", 0, 1'b1);
        end_instr = 1'b0; mem_ready = 1'b0;

        // Three wait cycles in T1 (one short of timeout)
        tick(); exp_step("wait_t1_first", 1, 1'b1);
        tick(); exp_step("wait_1", 1, 1'b0);
        tick(); exp_step("wait_2", 1, 1'b0);
        tick(); exp_step("wait_3", 1, 1'b0);
        mem_ready = 1'b1;
        tick(); exp_step("wait_t2", 2, 1'b1);

        // No end_instr: implicit end at T7, then T0
        for (int i = 3; i <= 7; i++) begin
            tick(); exp_step($sformatf("implicit_t%0d", i), i, 1'b1);
        end
        tick(); exp_step("implicit_wrap_t0", 0, 1'b1);

        // Memory never ready: fault on the fourth wait, sticky until clear
        mem_ready = 1'b0;
        tick(); exp_step("to_t1_first", 1, 1'b1);
        tick(); exp_step("to_wait1", 1, 1'b0);
        tick(); exp_step("to_wait2", 1, 1'b0);
        tick(); exp_step("to_wait3", 1, 1'b0);
        tick(); exp_fault("to_fault");
        mem_ready = 1'b1;
        tick(); exp_fault("fault_sticky1");
        tick(); exp_fault("fault_sticky2");
        clear = 1'b0;
        tick(); exp_idle("fault_clear");
        clear = 1'b1; run = 1'b0;
        tick(); exp_idle("post_clear_idle");

        // end_instr ignored during fetch, honoured at T3
        run = 1'b1; end_instr = 1'b1;
        tick(); exp_step("ign_t0", 0, 1'b1);
        tick(); exp_step("ign_t1", 1, 1'b1);
        tick(); exp_step("ign_t2", 2, 1'b1);
        tick(); exp_step("ign_t3", 3, 1'b1);
        tick(); exp_step("early_end_t0", 0, 1'b1);
        end_instr = 1'b0;

        // halt_req mid-execute: instruction completes, then HALT
        tick(); exp_step("h_t1", 1, 1'b1);
        tick(); exp_step("h_t2", 2, 1'b1);
        tick(); exp_step("h_t3", 3, 1'b1);
        halt_req = 1'b1;
        tick(); exp_step("halt_mid_t4", 4, 1'b1);
        tick(); exp_step("halt_mid_t5", 5, 1'b1);
        end_instr = 1'b1;
        tick(); exp_halt("halt_entry");
        end_instr = 1'b0;
        tick(); exp_halt("halt_hold");
        halt_req = 1'b0;
        tick(); exp_step("halt_resume_t0", 0, 1'b1);

        // run dropped mid-instruction: finishes, then IDLE
        tick(); exp_step("rd_t1", 1, 1'b1);
        tick(); exp_step("rd_t2", 2, 1'b1);
        tick(); exp_step("rd_t3", 3, 1'b1);
        run = 1'b0;
        tick(); exp_step("rundrop_t4", 4, 1'b1);
        end_instr = 1'b1;
        tick(); exp_idle("rundrop_idle");
        end_instr = 1'b0;

        // clear during T1 wait, then during T5
        run = 1'b1; mem_ready = 1'b0;
        tick(); exp_step("c_t0", 0, 1'b1);
        tick(); exp_step("c_t1_first", 1, 1'b1);
        tick(); exp_step("c_wait1", 1, 1'b0);
        tick(); exp_step("c_wait2", 1, 1'b0);
        clear = 1'b0;
        tick(); exp_idle("clr_in_t1");
        clear = 1'b1;
        tick(); exp_step("c2_t0", 0, 1'b1);
        tick(); exp_step("c2_t1_first", 1, 1'b1);
        tick(); exp_step("c2_wait1", 1, 1'b0);
        tick(); exp_step("c2_wait2", 1, 1'b0);
        tick(); exp_step("c2_wait3", 1, 1'b0);
        mem_ready = 1'b1;
        tick(); exp_step("c2_t2", 2, 1'b1);
        tick(); exp_step("c2_t3", 3, 1'b1);
        tick(); exp_step("c2_t4", 4, 1'b1);
        tick(); exp_step("c2_t5", 5, 1'b1);
        clear = 1'b0;
        tick(); exp_idle("clr_in_t5");
        clear = 1'b1; run = 1'b0;
        tick(); exp_idle("final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
